// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I/D requester handshakes and the shared memory port.
// slave = arbiter view, master = requesters + memory view.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [1:0]  d_size;
  logic        d_sign;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_size, d_sign, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_size, mem_sign, mem_wdata, mem_wen, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_size, d_sign, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_size, mem_sign, mem_wdata, mem_wen, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an I-fetch reader and a D read/write requester.
// D has priority; I is forced through after STARVE_MAX consecutive D wins.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic              CLK,
  input  logic              RST,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] wdata;
    logic        write;
  } req_t;

  localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);
  localparam logic [3:0] SMAX     = 4'(STARVE_MAX);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [3:0]  starve_cnt;
  logic        owner_i;
  req_t        req_q;
  logic [31:0] i_rdata_q, d_rdata_q;
  logic        win_i, win_d, last_acc;

  assign win_i    = bus.i_req & (~bus.d_req | (starve_cnt == SMAX));
  assign win_d    = bus.d_req & ~win_i;
  assign last_acc = (state == ACCESS) && (cnt == 3'd0);

  always_ff @(negedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_i | win_d) state_nxt = ACCESS;
      ACCESS:  if (cnt == 3'd0)   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      cnt        <= '0;
      starve_cnt <= '0;
      owner_i    <= 1'b0;
      req_q      <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (state == IDLE) begin
        cnt <= LAST_CNT;
        if (win_i) begin
          owner_i    <= 1'b1;
          req_q      <= '{addr: bus.i_addr, size: 2'b10, sign: 1'b0, wdata: 32'd0, write: 1'b0};
          starve_cnt <= '0;
        end else if (win_d) begin
          owner_i <= 1'b0;
          req_q   <= '{addr: bus.d_addr, size: bus.d_size, sign: bus.d_sign,
                       wdata: bus.d_wdata, write: ~bus.d_wen};
          // Only D wins that actually made I wait count toward forcing I through
          if (bus.i_req && starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
        end
      end else if (state == ACCESS && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (last_acc && !req_q.write) begin
        if (owner_i) i_rdata_q <= bus.mem_rdata;
        else         d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // Everything below decodes from flops, except the grants which must answer in the request cycle
  always_comb begin
    bus.i_gnt     = (state == IDLE) & win_i;
    bus.d_gnt     = (state == IDLE) & win_d;
    bus.i_rvalid  = (state == RESP) &  owner_i;
    bus.d_rvalid  = (state == RESP) & ~owner_i;
    bus.busy      = (state != IDLE);
    bus.mem_wen   = ~(last_acc & req_q.write);
    bus.mem_addr  = req_q.addr;
    bus.mem_size  = req_q.size;
    bus.mem_sign  = req_q.sign;
    bus.mem_wdata = req_q.wdata;
    bus.i_rdata   = i_rdata_q;
    bus.d_rdata   = d_rdata_q;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: per-cycle vector table on a MEM_LAT=1 arbiter, hand sequences on MEM_LAT=3.
module tb_mem_port_arbiter;
  logic CLK = 1'b0;
  logic rst1, rst3, mem_ld;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b3 ();

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) u_lat1 (.CLK(CLK), .RST(rst1), .bus(b1.slave));
  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(3)) u_lat3 (.CLK(CLK), .RST(rst3), .bus(b3.slave));

  // Byte-addressed memories, little-endian, aligning by size on access
  logic [7:0] m1 [256];
  logic [7:0] m3 [256];
  logic [7:0] a1, a3;
  assign a1 = b1.mem_addr[7:0];
  assign a3 = b3.mem_addr[7:0];

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] lo,
                                      input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lo +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   return {{24{sg & b[7]}}, b};
      2'b01:   return {{16{sg & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  assign b1.mem_rdata = fmt({m1[{a1[7:2], 2'd3}], m1[{a1[7:2], 2'd2}], m1[{a1[7:2], 2'd1}],
                             m1[{a1[7:2], 2'd0}]}, a1[1:0], b1.mem_size, b1.mem_sign);
  assign b3.mem_rdata = fmt({m3[{a3[7:2], 2'd3}], m3[{a3[7:2], 2'd2}], m3[{a3[7:2], 2'd1}],
                             m3[{a3[7:2], 2'd0}]}, a3[1:0], b3.mem_size, b3.mem_sign);

  always @(posedge CLK) begin
    if (mem_ld) begin
      for (int k = 0; k < 256; k++) begin
        m1[k] <= 8'h00;
        m3[k] <= 8'h00;
      end
      {m1[8'h13], m1[8'h12], m1[8'h11], m1[8'h10]} <= 32'hDEADBEEF;
      {m1[8'h23], m1[8'h22], m1[8'h21], m1[8'h20]} <= 32'h12345678;
      {m3[8'h23], m3[8'h22], m3[8'h21], m3[8'h20]} <= 32'h12345678;
    end else if (!b3.mem_wen) begin
      case (b3.mem_size)
        2'b00: m3[a3] <= b3.mem_wdata[7:0];
        2'b01: begin
          m3[{a3[7:1], 1'b0}] <= b3.mem_wdata[7:0];
          m3[{a3[7:1], 1'b1}] <= b3.mem_wdata[15:8];
        end
        default: {m3[{a3[7:2], 2'd3}], m3[{a3[7:2], 2'd2}], m3[{a3[7:2], 2'd1}],
                  m3[{a3[7:2], 2'd0}]} <= b3.mem_wdata;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string nm, input logic [31:0] exp_addr, input logic [31:0] exp_rd);
    chk({nm, "_busy"},  b1.busy,     1'b0);
    chk({nm, "_wen"},   b1.mem_wen,  1'b1);
    chk({nm, "_gnt"},   {b1.i_gnt, b1.d_gnt}, 2'b00);
    chk({nm, "_rv"},    {b1.i_rvalid, b1.d_rvalid}, 2'b00);
    chk({nm, "_maddr"}, b1.mem_addr, exp_addr);
    chk({nm, "_irdat"}, b1.i_rdata,  exp_rd);
  endtask

  typedef struct {
    logic        ireq, dreq, igt, dgt, irv, drv, busy;
    logic [31:0] maddr, rdata;
  } vec_t;

  function automatic vec_t mk(input logic ireq, dreq, igt, dgt, irv, drv, busy,
                              input logic [31:0] maddr, rdata);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.igt = igt; v.dgt = dgt;
    v.irv = irv; v.drv = drv; v.busy = busy; v.maddr = maddr; v.rdata = rdata;
    return v;
  endfunction

  // One D access on the MEM_LAT=3 port: grant, three ACCESS cycles, RESP
  task automatic d_op3(input string nm, input logic wr, input logic [31:0] addr,
                       input logic [1:0] size, input logic sign, input logic [31:0] wd,
                       input logic [31:0] exp_rd);
    @(negedge CLK); #1;
    b3.d_req = 1'b1; b3.d_wen = ~wr; b3.d_addr = addr;
    b3.d_size = size; b3.d_sign = sign; b3.d_wdata = wd;
    @(posedge CLK);
    chk({nm, "_gnt"}, b3.d_gnt, 1'b1);
    @(negedge CLK); #1;
    b3.d_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      chk({nm, "_wen"},   b3.mem_wen, (wr && c == 2) ? 1'b0 : 1'b1);
      chk({nm, "_busy"},  b3.busy, 1'b1);
      chk({nm, "_rv"},    b3.d_rvalid, 1'b0);
      chk({nm, "_maddr"}, b3.mem_addr, addr);
      chk({nm, "_msize"}, b3.mem_size, size);
      chk({nm, "_msign"}, b3.mem_sign, sign);
      if (wr && c == 2) chk({nm, "_wdata"}, b3.mem_wdata, wd);
    end
    @(posedge CLK);
    chk({nm, "_rvalid"}, b3.d_rvalid, 1'b1);
    chk({nm, "_wenr"},   b3.mem_wen, 1'b1);
    if (!wr) chk({nm, "_rdata"}, b3.d_rdata, exp_rd);
  endtask

  vec_t tv[26];

  initial begin
    rst1 = 1'b0; rst3 = 1'b0; mem_ld = 1'b1;
    b1.i_req = 0; b1.i_addr = 32'h10; b1.d_req = 0; b1.d_wen = 1; b1.d_addr = 32'h20;
    b1.d_size = 2'b10; b1.d_sign = 0; b1.d_wdata = 0;
    b3.i_req = 0; b3.i_addr = 0; b3.d_req = 0; b3.d_wen = 1; b3.d_addr = 0;
    b3.d_size = 0; b3.d_sign = 0; b3.d_wdata = 0;

    // Single I read, then D-vs-I collision, then starvation with both held high
    tv[0] = mk(0,0, 0,0,0,0,0, 32'h00, 0);
    tv[1] = mk(1,0, 1,0,0,0,0, 32'h00, 0);
    tv[2] = mk(0,0, 0,0,0,0,1, 32'h10, 0);
    tv[3] = mk(0,0, 0,0,1,0,1, 32'h10, 32'hDEADBEEF);
    tv[4] = mk(1,1, 0,1,0,0,0, 32'h10, 0);
    tv[5] = mk(1,0, 0,0,0,0,1, 32'h20, 0);
    tv[6] = mk(1,0, 0,0,0,1,1, 32'h20, 32'h12345678);
    tv[7] = mk(1,0, 1,0,0,0,0, 32'h20, 0);
    tv[8] = mk(0,0, 0,0,0,0,1, 32'h10, 0);
    tv[9] = mk(0,0, 0,0,1,0,1, 32'h10, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      logic        is_i;
      logic [31:0] prev, own, dat;
      is_i = (k == 3);
      prev = (k == 0 || k == 4) ? 32'h10 : 32'h20;
      own  = is_i ? 32'h10 : 32'h20;
      dat  = is_i ? 32'hDEADBEEF : 32'h12345678;
      tv[10 + 3*k] = mk(1,1, is_i,~is_i,0,0,0, prev, 0);
      tv[11 + 3*k] = mk(1,1, 0,0,0,0,1, own, 0);
      tv[12 + 3*k] = mk(1,1, 0,0,is_i,~is_i,1, own, dat);
    end
    tv[25] = mk(0,0, 0,0,0,0,0, 32'h20, 0);

    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    mem_ld = 1'b0;
    @(posedge CLK);
    chk_idle("rst_hold", 32'h0, 32'h0);
    chk("rst_hold_l3wen", b3.mem_wen, 1'b1);
    @(negedge CLK); #1;
    rst1 = 1'b1; rst3 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      chk_idle("rst_rel", 32'h0, 32'h0);
      chk("rst_rel_drdat", b1.d_rdata, 32'h0);
    end

    for (int i = 0; i < 26; i++) begin
      @(negedge CLK); #1;
      b1.i_req = tv[i].ireq;
      b1.d_req = tv[i].dreq;
      @(posedge CLK);
      chk($sformatf("v%0d_igt", i),   b1.i_gnt,    tv[i].igt);
      chk($sformatf("v%0d_dgt", i),   b1.d_gnt,    tv[i].dgt);
      chk($sformatf("v%0d_irv", i),   b1.i_rvalid, tv[i].irv);
      chk($sformatf("v%0d_drv", i),   b1.d_rvalid, tv[i].drv);
      chk($sformatf("v%0d_busy", i),  b1.busy,     tv[i].busy);
      chk($sformatf("v%0d_wen", i),   b1.mem_wen,  1'b1);
      chk($sformatf("v%0d_maddr", i), b1.mem_addr, tv[i].maddr);
      if (tv[i].irv) chk($sformatf("v%0d_irdat", i), b1.i_rdata, tv[i].rdata);
      if (tv[i].drv) chk($sformatf("v%0d_drdat", i), b1.d_rdata, tv[i].rdata);
      if (i == 2 || i == 8) chk($sformatf("v%0d_msize", i), b1.mem_size, 2'b10);
    end

    // Byte write then sign/size variants reading it back
    d_op3("wr_b21",  1'b1, 32'h21, 2'b00, 1'b0, 32'h777777A5, 32'h0);
    d_op3("rd_b21u", 1'b0, 32'h21, 2'b00, 1'b0, 32'h0, 32'h000000A5);
    d_op3("rd_b21s", 1'b0, 32'h21, 2'b00, 1'b1, 32'h0, 32'hFFFFFFA5);
    d_op3("rd_w11",  1'b0, 32'h22, 2'b11, 1'b0, 32'h0, 32'h1234A578);
    d_op3("rd_h20s", 1'b0, 32'h20, 2'b01, 1'b1, 32'h0, 32'hFFFFA578);

    // Reset during the first ACCESS cycle of a write: the strobe must never happen
    @(negedge CLK); #1;
    b3.d_req = 1'b1; b3.d_wen = 1'b0; b3.d_addr = 32'h22;
    b3.d_size = 2'b00; b3.d_sign = 1'b0; b3.d_wdata = 32'h5A;
    @(posedge CLK);
    chk("abort_gnt", b3.d_gnt, 1'b1);
    @(negedge CLK); #1;
    b3.d_req = 1'b0;
    rst3 = 1'b0;
    @(posedge CLK);
    chk("abort_busy", b3.busy, 1'b0);
    chk("abort_wen",  b3.mem_wen, 1'b1);
    chk("abort_rv",   b3.d_rvalid, 1'b0);
    @(negedge CLK); #1;
    rst3 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      chk("post_busy",  b3.busy, 1'b0);
      chk("post_wen",   b3.mem_wen, 1'b1);
      chk("post_rv",    b3.d_rvalid, 1'b0);
      chk("post_maddr", b3.mem_addr, 32'h0);
      chk("post_drdat", b3.d_rdata, 32'h0);
    end
    chk("abort_byte", {24'h0, m3[8'h22]}, 32'h34);
    chk("kept_byte",  {24'h0, m3[8'h21]}, 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
